// File: rtl/pwr_seq_pkg.sv
// Shared definitions for the power sequencer: state encoding and small
// width/priority helpers used by the top and the tick timer.
package pwr_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_UP_PG  = 3'd1,
    ST_UP_DLY = 3'd2,
    ST_ON     = 3'd3,
    ST_DN_DLY = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int v;
    int w;
    v = value - 1;
    w = 0;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    if (w == 0) begin
      w = 1;
    end
    return w;
  endfunction

  // Index of the lowest set bit; zero when no bit is set.
  function automatic logic [2:0] lowest_idx(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/pwr_seq_tick_timer.sv
// Tick-qualified saturating counter shared by the delay and timeout phases.
// Clear beats tick; done compares the held count against a per-phase limit.
module pwr_seq_tick_timer
  import pwr_seq_pkg::*;
#(
  parameter int MAX_TICKS = 100,
  parameter int CW        = clog2(MAX_TICKS + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          tick_i,
  input  logic          clr_i,
  input  logic [CW-1:0] limit_i,
  output logic          done_o
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_TICKS);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear first, otherwise advance on tick until saturated.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {CW{1'b0}};
    end else if (tick_i && (count_q != MAX_C)) begin
      count_d = count_q + CW'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == limit_i);

endmodule

// File: rtl/pwr_seq_timer.sv
// Multi-rail power sequencer: enables rails in order on request, gated by
// power-good, timeout and inter-rail delay, and disables them in reverse.
module pwr_seq_timer
  import pwr_seq_pkg::*;
#(
  parameter int NUM_RAILS     = 4,
  parameter int DLY_TICKS     = 10,
  parameter int TIMEOUT_TICKS = 100
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iTick,
  input  logic                 iPwrReq,
  input  logic [NUM_RAILS-1:0] iPwrgd,
  input  logic                 iFaultClr,
  output logic [NUM_RAILS-1:0] oEn,
  output logic                 oAllPwrgd,
  output logic                 oFault,
  output logic [2:0]           oFaultIdx,
  output logic [2:0]           oState
);

  localparam int                   TW       = clog2(TIMEOUT_TICKS + 1);
  localparam logic [NUM_RAILS-1:0] RAIL0    = NUM_RAILS'(1'b1);
  localparam logic [2:0]           LAST_IDX = 3'(NUM_RAILS - 1);
  localparam logic [TW-1:0]        DLY_LIM  = TW'(DLY_TICKS);
  localparam logic [TW-1:0]        TO_LIM   = TW'(TIMEOUT_TICKS);

  state_e               state_q;
  logic [2:0]           idx_q;
  logic [NUM_RAILS-1:0] en_q;
  logic                 allpg_q;
  logic                 fault_q;
  logic [2:0]           fault_idx_q;

  logic [NUM_RAILS-1:0] idx_bit_s;
  logic [NUM_RAILS-1:0] below_mask_s;
  logic [NUM_RAILS-1:0] thru_mask_s;
  logic [NUM_RAILS-1:0] watch_s;
  logic [NUM_RAILS-1:0] lost_s;
  logic                 lost_any_s;
  logic [2:0]           lost_idx_s;
  logic                 cur_pg_s;
  logic                 tmo_s;
  logic                 fault_go_s;
  logic [2:0]           fault_at_s;
  logic                 tmr_clr_s;
  logic [TW-1:0]        tmr_limit_s;
  logic                 tmr_done_s;

  assign idx_bit_s    = RAIL0 << idx_q;
  assign below_mask_s = idx_bit_s - RAIL0;
  assign thru_mask_s  = (idx_bit_s << 3'd1) - RAIL0;
  assign cur_pg_s     = |(iPwrgd & idx_bit_s);

  // Rails whose power-good must already hold in the current state.
  always_comb begin
    watch_s = {NUM_RAILS{1'b0}};
    case (state_q)
      ST_UP_PG:         watch_s = below_mask_s;
      ST_UP_DLY, ST_ON: watch_s = thru_mask_s;
      default:          watch_s = {NUM_RAILS{1'b0}};
    endcase
  end

  assign lost_s     = watch_s & ~iPwrgd;
  assign lost_any_s = |lost_s;
  assign lost_idx_s = lowest_idx(8'(lost_s));

  // A rail coming good on the timeout cycle is accepted, not faulted.
  assign tmo_s      = (state_q == ST_UP_PG) && !cur_pg_s && tmr_done_s;
  assign fault_go_s = lost_any_s || tmo_s;
  assign fault_at_s = lost_any_s ? lost_idx_s : idx_q;

  // Timer clear: held clear whenever no phase is being timed.
  always_comb begin
    tmr_clr_s = 1'b1;
    case (state_q)
      ST_UP_PG:  tmr_clr_s = !iPwrReq || cur_pg_s;
      ST_UP_DLY: tmr_clr_s = !iPwrReq || tmr_done_s;
      ST_DN_DLY: tmr_clr_s = tmr_done_s;
      default:   tmr_clr_s = 1'b1;
    endcase
  end

  assign tmr_limit_s = (state_q == ST_UP_PG) ? TO_LIM : DLY_LIM;

  pwr_seq_tick_timer #(
    .MAX_TICKS (TIMEOUT_TICKS),
    .CW        (TW)
  ) u_timer (
    .clk_i   (iClk),
    .rst_ni  (iRst_n),
    .tick_i  (iTick),
    .clr_i   (tmr_clr_s),
    .limit_i (tmr_limit_s),
    .done_o  (tmr_done_s)
  );

  // Sequencing FSM; faults pre-empt every other decision.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= ST_OFF;
      idx_q       <= 3'd0;
      en_q        <= {NUM_RAILS{1'b0}};
      allpg_q     <= 1'b0;
      fault_q     <= 1'b0;
      fault_idx_q <= 3'd0;
    end else if (fault_go_s) begin
      state_q     <= ST_FAULT;
      en_q        <= {NUM_RAILS{1'b0}};
      allpg_q     <= 1'b0;
      fault_q     <= 1'b1;
      fault_idx_q <= fault_at_s;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (iPwrReq && !fault_q) begin
            en_q    <= RAIL0;
            idx_q   <= 3'd0;
            state_q <= ST_UP_PG;
          end else if (iFaultClr && !iPwrReq) begin
            fault_q <= 1'b0;
          end
        end
        ST_UP_PG: begin
          if (!iPwrReq) begin
            en_q    <= en_q & ~idx_bit_s;
            state_q <= ST_DN_DLY;
          end else if (cur_pg_s) begin
            state_q <= ST_UP_DLY;
          end
        end
        ST_UP_DLY: begin
          if (!iPwrReq) begin
            en_q    <= en_q & ~idx_bit_s;
            state_q <= ST_DN_DLY;
          end else if (tmr_done_s) begin
            if (idx_q == LAST_IDX) begin
              allpg_q <= 1'b1;
              state_q <= ST_ON;
            end else begin
              idx_q   <= idx_q + 3'd1;
              en_q    <= en_q | (idx_bit_s << 3'd1);
              state_q <= ST_UP_PG;
            end
          end
        end
        ST_ON: begin
          if (!iPwrReq) begin
            en_q    <= en_q & ~idx_bit_s;
            idx_q   <= LAST_IDX;
            allpg_q <= 1'b0;
            state_q <= ST_DN_DLY;
          end
        end
        // Power-down always runs to completion, whatever iPwrReq does.
        ST_DN_DLY: begin
          if (tmr_done_s) begin
            if (idx_q == 3'd0) begin
              state_q <= ST_OFF;
            end else begin
              idx_q <= idx_q - 3'd1;
              en_q  <= en_q & ~(idx_bit_s >> 3'd1);
            end
          end
        end
        ST_FAULT: begin
          if (!iPwrReq) begin
            state_q <= ST_OFF;
          end
        end
        default: begin
          state_q <= ST_OFF;
          en_q    <= {NUM_RAILS{1'b0}};
          allpg_q <= 1'b0;
        end
      endcase
    end
  end

  assign oEn       = en_q;
  assign oAllPwrgd = allpg_q;
  assign oFault    = fault_q;
  assign oFaultIdx = fault_idx_q;
  assign oState    = state_q;

endmodule

// File: tb/tb_pwr_seq_timer.sv
// Directed bench for pwr_seq_timer with 3 rails, 2-tick delay, 5-tick timeout
// and a tick every 4th clock; expected values are worked out by hand.
module tb_pwr_seq_timer;

  logic       clk = 1'b0;
  logic       iRst_n;
  logic       iTick;
  logic       iPwrReq;
  logic [2:0] iPwrgd;
  logic       iFaultClr;
  logic [2:0] oEn;
  logic       oAllPwrgd;
  logic       oFault;
  logic [2:0] oFaultIdx;
  logic [2:0] oState;

  int         errors    = 0;
  int         checks    = 0;
  int         tick_seen = 0;
  int         mark      = 0;
  logic [1:0] ph        = 2'd0;

  pwr_seq_timer #(
    .NUM_RAILS     (3),
    .DLY_TICKS     (2),
    .TIMEOUT_TICKS (5)
  ) dut (
    .iClk      (clk),
    .iRst_n    (iRst_n),
    .iTick     (iTick),
    .iPwrReq   (iPwrReq),
    .iPwrgd    (iPwrgd),
    .iFaultClr (iFaultClr),
    .oEn       (oEn),
    .oAllPwrgd (oAllPwrgd),
    .oFault    (oFault),
    .oFaultIdx (oFaultIdx),
    .oState    (oState)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: tick on every 4th edge, sample #1 after the edge.
  task automatic cyc();
    iTick = (ph == 2'd3);
    ph = ph + 2'd1;
    @(posedge clk);
    #1;
    if (iTick) tick_seen++;
  endtask

  task automatic wait_ticks(input int n);
    int start;
    start = tick_seen;
    while (tick_seen - start < n) cyc();
  endtask

  function automatic logic [31:0] sel(input int which);
    case (which)
      0:       return 32'(oEn);
      1:       return 32'(oState);
      2:       return 32'(oFault);
      default: return 32'(oAllPwrgd);
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input logic [31:0] exp);
    logic [31:0] cur;
    int n;
    n = 0;
    cur = sel(which);
    while (cur !== exp && n < 200) begin
      cyc();
      n++;
      cur = sel(which);
    end
    chk(tag, cur, exp);
  endtask

  initial begin
    iRst_n = 1'b0; iTick = 1'b0; iPwrReq = 1'b0; iPwrgd = 3'b000; iFaultClr = 1'b0;
    repeat (3) cyc();
    chk("rst_en",     32'(oEn),       32'd0);
    chk("rst_allpg",  32'(oAllPwrgd), 32'd0);
    chk("rst_fault",  32'(oFault),    32'd0);
    chk("rst_fidx",   32'(oFaultIdx), 32'd0);
    chk("rst_state",  32'(oState),    32'd0);
    iRst_n = 1'b1;
    cyc();
    chk("idle_state", 32'(oState),    32'd0);

    // Normal power-up
    iPwrReq = 1'b1; cyc();
    chk("up_en0",   32'(oEn),    32'd1);
    chk("up_state", 32'(oState), 32'd1);
    wait_ticks(3); iPwrgd = 3'b001; mark = tick_seen;
    wait_for("up_en1", 0, 32'd3);
    chk("up_dly1_ticks", 32'(tick_seen - mark), 32'd2);
    wait_ticks(3); iPwrgd = 3'b011; mark = tick_seen;
    wait_for("up_en2", 0, 32'd7);
    chk("up_dly2_ticks", 32'(tick_seen - mark), 32'd2);
    wait_ticks(3); iPwrgd = 3'b111; mark = tick_seen;
    wait_for("up_allpg", 3, 32'd1);
    chk("up_dly3_ticks", 32'(tick_seen - mark), 32'd2);
    chk("on_en",    32'(oEn),    32'd7);
    chk("on_fault", 32'(oFault), 32'd0);
    chk("on_state", 32'(oState), 32'd3);

    // Power-down from ST_ON
    iPwrReq = 1'b0; cyc();
    chk("dn_en2",   32'(oEn),       32'd3);
    chk("dn_allpg", 32'(oAllPwrgd), 32'd0);
    chk("dn_state", 32'(oState),    32'd4);
    mark = tick_seen; wait_for("dn_en1", 0, 32'd1);
    chk("dn_gap1", 32'(tick_seen - mark), 32'd2);
    mark = tick_seen; wait_for("dn_en0", 0, 32'd0);
    chk("dn_gap2", 32'(tick_seen - mark), 32'd2);
    mark = tick_seen; wait_for("dn_off", 1, 32'd0);
    chk("dn_gap3", 32'(tick_seen - mark), 32'd2);
    iPwrgd = 3'b000;

    // Timeout on rail 1
    iPwrReq = 1'b1; cyc();
    chk("to_en0", 32'(oEn), 32'd1);
    wait_ticks(3); iPwrgd = 3'b001;
    wait_for("to_en1", 0, 32'd3);
    mark = tick_seen; wait_for("to_fault", 2, 32'd1);
    chk("to_ticks", 32'(tick_seen - mark), 32'd5);
    chk("to_en",    32'(oEn),       32'd0);
    chk("to_fidx",  32'(oFaultIdx), 32'd1);
    chk("to_state", 32'(oState),    32'd5);
    iPwrReq = 1'b0; cyc();
    chk("to_off",    32'(oState), 32'd0);
    chk("to_sticky", 32'(oFault), 32'd1);
    iFaultClr = 1'b1; cyc(); iFaultClr = 1'b0;
    chk("to_clr", 32'(oFault), 32'd0);
    iPwrgd = 3'b000;

    // Abort during ST_UP_DLY at idx=1
    iPwrReq = 1'b1; cyc();
    chk("ab_en0", 32'(oEn), 32'd1);
    wait_ticks(3); iPwrgd = 3'b001;
    wait_for("ab_en1", 0, 32'd3);
    wait_ticks(3); iPwrgd = 3'b011; cyc();
    chk("ab_state_dly", 32'(oState), 32'd2);
    iPwrReq = 1'b0; cyc();
    chk("ab_en",    32'(oEn),    32'd1);
    chk("ab_state", 32'(oState), 32'd4);
    mark = tick_seen; wait_for("ab_en_off", 0, 32'd0);
    chk("ab_gap", 32'(tick_seen - mark), 32'd2);
    wait_for("ab_off", 1, 32'd0);
    iPwrgd = 3'b000;

    // Power-good arrives on the timeout cycle
    iPwrReq = 1'b1; cyc();
    chk("co_en0", 32'(oEn), 32'd1);
    wait_ticks(5); iPwrgd = 3'b001; cyc();
    chk("co_state",   32'(oState), 32'd2);
    chk("co_nofault", 32'(oFault), 32'd0);
    wait_for("co_en1", 0, 32'd3);
    wait_ticks(3); iPwrgd = 3'b011;
    wait_for("co_en2", 0, 32'd7);
    wait_ticks(3); iPwrgd = 3'b111;
    wait_for("co_on", 3, 32'd1);

    // Power-good loss on rail 0 while on
    iPwrgd = 3'b110; cyc();
    chk("pgl_en",    32'(oEn),       32'd0);
    chk("pgl_fault", 32'(oFault),    32'd1);
    chk("pgl_fidx",  32'(oFaultIdx), 32'd0);
    chk("pgl_state", 32'(oState),    32'd5);
    chk("pgl_allpg", 32'(oAllPwrgd), 32'd0);
    iFaultClr = 1'b1; cyc(); iFaultClr = 1'b0;
    chk("pgl_clr_ignored", 32'(oFault), 32'd1);
    iPwrReq = 1'b0; cyc();
    chk("pgl_off", 32'(oState), 32'd0);
    iFaultClr = 1'b1; cyc(); iFaultClr = 1'b0;
    chk("pgl_clr", 32'(oFault), 32'd0);
    iPwrgd = 3'b000;

    // Asynchronous reset in ST_UP_PG
    iPwrReq = 1'b1; cyc();
    chk("ar_en0",   32'(oEn),    32'd1);
    chk("ar_state", 32'(oState), 32'd1);
    #2; iRst_n = 1'b0; #1;
    chk("ar_en_async",    32'(oEn),       32'd0);
    chk("ar_state_async", 32'(oState),    32'd0);
    chk("ar_allpg_async", 32'(oAllPwrgd), 32'd0);
    #3; iRst_n = 1'b1;
    cyc();
    chk("ar_restart_en",    32'(oEn),    32'd1);
    chk("ar_restart_state", 32'(oState), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
